// File: rtl/puertos_salida_if.sv
// Write channel into the output-port bank: address/data pair with valid/ready handshake.
interface puertos_salida_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] dir_in;
  logic [7:0] dato_in;

  modport master (output wr_valid, output dir_in, output dato_in, input wr_ready);
  modport slave  (input wr_valid, input dir_in, input dato_in, output wr_ready);
endinterface

// File: rtl/puertos_salida.sv
// Output-port bank: 2-entry write FIFO, address decode, NUM_PUERTOS 8-bit registered ports.
// Optional register readback enabled by defining PUERTOS_READBACK_EN.
module puertos_salida #(
  parameter int         NUM_PUERTOS = 4,
  parameter logic [7:0] DIR_BASE    = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  puertos_salida_if.slave          wr,
  output logic [8*NUM_PUERTOS-1:0] puerto_out,
  output logic [NUM_PUERTOS-1:0]   puerto_wr,
  output logic                     err_dir
`ifdef PUERTOS_READBACK_EN
  ,
  input  logic [7:0]               rd_dir,
  output logic [7:0]               rd_dato
`endif
);

  logic [7:0] dir_mem  [2];
  logic [7:0] dato_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       ready_q;
  logic       push;
  logic       pop;
  logic [8:0] offset;
  logic       in_range;
  logic [7:0] idx;

  assign wr.wr_ready = ready_q;
  assign push        = wr.wr_valid && ready_q;
  assign pop         = (count != 2'd0);

  // 9-bit subtraction: bit 8 is the borrow, so it flags dir < DIR_BASE without wrap.
  assign offset   = {1'b0, dir_mem[rd_ptr]} - {1'b0, DIR_BASE};
  assign idx      = offset[7:0];
  assign in_range = !offset[8] && (idx < 8'(NUM_PUERTOS));

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dir_mem[wr_ptr]  <= wr.dir_in;
      dato_mem[wr_ptr] <= wr.dato_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      ready_q    <= 1'b1;
      puerto_out <= '0;
      puerto_wr  <= '0;
      err_dir    <= 1'b0;
    end else begin
      count     <= count_next;
      ready_q   <= (count_next != 2'd2);
      puerto_wr <= '0;
      err_dir   <= 1'b0;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (in_range) begin
          for (int i = 0; i < NUM_PUERTOS; i++) begin
            if (idx == 8'(i)) begin
              puerto_out[8*i +: 8] <= dato_mem[rd_ptr];
              puerto_wr[i]         <= 1'b1;
            end
          end
        end else begin
          err_dir <= 1'b1;
        end
      end
    end
  end

`ifdef PUERTOS_READBACK_EN
  logic [8:0] rd_offset;
  logic [7:0] rd_idx;
  logic       rd_in_range;
  logic [7:0] rd_val;

  assign rd_offset   = {1'b0, rd_dir} - {1'b0, DIR_BASE};
  assign rd_idx      = rd_offset[7:0];
  assign rd_in_range = !rd_offset[8] && (rd_idx < 8'(NUM_PUERTOS));

  // Reads the current register contents, so a same-edge update is not bypassed.
  always_comb begin
    rd_val = 8'h00;
    if (rd_in_range) begin
      for (int i = 0; i < NUM_PUERTOS; i++) begin
        if (rd_idx == 8'(i)) rd_val = puerto_out[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_dato <= 8'h00;
    else        rd_dato <= rd_val;
  end
`endif

endmodule
